// File: rtl/adc_scan_sequencer_if.sv
// Result hand-off port of the ADC scan sequencer: a channel-tagged
// conversion value offered over valid/ready, plus the overrun pulse that
// flags a result lost because the consumer had not taken it in time.
`timescale 1ns/1ps

interface adc_scan_sequencer_if #(
  parameter int RES_W = 12
) ();
  logic             result_valid;
  logic             result_ready;
  logic [2:0]       result_ch;
  logic [RES_W-1:0] result_data;
  logic             overrun;

  modport master (
    output result_valid, result_ch, result_data, overrun,
    input  result_ready
  );

  modport slave (
    input  result_valid, result_ch, result_data, overrun,
    output result_ready
  );
endinterface

// File: rtl/adc_scan_sequencer.sv
// Autonomous scan controller for an 8-channel convert-then-shift SPI ADC.
// Walks the enabled channels in ascending order. Because the ADC returns the
// result of the previous transaction, every scan starts with a dummy
// transaction and ends with one that re-addresses the first channel.
`timescale 1ns/1ps

module adc_scan_sequencer #(
  parameter int CLK_DIV     = 2,
  parameter int CONV_CYCLES = 100,
  parameter int RES_W       = 12
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [7:0]            ch_enable,
  input  logic                  scan_start,
  input  logic                  continuous,
  output logic                  busy,
  output logic                  scan_done,
  adc_scan_sequencer_if.master  res,
  output logic                  adc_cs_n,
  output logic                  adc_sclk,
  output logic                  adc_din,
  input  logic                  adc_dout
);

  localparam int CNT_W = $clog2(CONV_CYCLES);
  localparam int PH_W  = $clog2(2 * CLK_DIV);
  localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(CONV_CYCLES - 1);
  localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(2 * CLK_DIV - 1);
  localparam logic [PH_W-1:0]  PH_RISE   = PH_W'(CLK_DIV);
  localparam logic [3:0]       BIT_LAST  = 4'd11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CONV  = 3'd1,
    S_SHIFT = 3'd2,
    S_GAP   = 3'd3,
    S_END   = 3'd4
  } state_t;

  // Lowest enabled channel of a mask (0 when the mask is empty).
  function automatic logic [2:0] first_ch(input logic [7:0] mask);
    logic [2:0] ch;
    ch = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i]) ch = 3'(i);
    end
    return ch;
  endfunction

  // Next enabled channel above cur, returned as {found, channel}.
  function automatic logic [3:0] next_ch(input logic [7:0] mask, input logic [2:0] cur);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i] && (i > int'(cur))) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  // Config word bit for SCLK period idx: S/D, O/S, S1, S0, UNI, SLP, then zeros.
  function automatic logic cfg_bit(input logic [2:0] ch, input logic [3:0] idx);
    logic b;
    case (idx)
      4'd0:    b = 1'b1;
      4'd1:    b = ch[0];
      4'd2:    b = ch[2];
      4'd3:    b = ch[1];
      4'd4:    b = 1'b1;
      default: b = 1'b0;
    endcase
    return b;
  endfunction

  state_t           state_r, state_nx;
  logic [CNT_W-1:0] cnt_r, cnt_nx;
  logic [PH_W-1:0]  ph_r, ph_nx;
  logic [3:0]       bit_r, bit_nx;
  logic [7:0]       mask_r, mask_nx;
  logic [2:0]       idx_r, idx_nx;     // channel addressed by this transaction
  logic [2:0]       src_r, src_nx;     // channel whose result this transaction returns
  logic             dummy_r, dummy_nx; // first transaction of a scan: result discarded
  logic             last_r, last_nx;   // final transaction of a scan
  logic [RES_W-1:0] shift_r, shift_nx;
  logic [3:0]       nch_s;
  logic             load_s, xfer_s, sclk_nx_s, din_nx_s;

  logic             busy_r, done_r, cs_r, sclk_r, din_r;
  logic             rv_r, ovr_r;
  logic [2:0]       rch_r;
  logic [RES_W-1:0] rdata_r;

  // Next-state, channel bookkeeping and pin timing for the scan FSM.
  always_comb begin
    state_nx = state_r;
    cnt_nx   = cnt_r;
    ph_nx    = ph_r;
    bit_nx   = bit_r;
    mask_nx  = mask_r;
    idx_nx   = idx_r;
    src_nx   = src_r;
    dummy_nx = dummy_r;
    last_nx  = last_r;
    shift_nx = shift_r;
    nch_s    = next_ch(mask_r, idx_r);
    case (state_r)
      S_IDLE: begin
        if (scan_start && (ch_enable != 8'd0)) begin
          mask_nx  = ch_enable;
          idx_nx   = first_ch(ch_enable);
          dummy_nx = 1'b1;
          last_nx  = 1'b0;
          cnt_nx   = '0;
          state_nx = S_CONV;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_CONV: begin
        if (cnt_r == CONV_LAST) begin
          ph_nx    = '0;
          bit_nx   = 4'd0;
          state_nx = S_SHIFT;
        end else begin
          cnt_nx = cnt_r + CNT_W'(1);
        end
      end
      S_SHIFT: begin
        if (ph_r == PH_RISE) begin
          shift_nx = {shift_r[RES_W-2:0], adc_dout};
        end else begin
          shift_nx = shift_r;
        end
        if (ph_r == PH_LAST) begin
          ph_nx = '0;
          if (bit_r == BIT_LAST) begin
            state_nx = S_GAP;
          end else begin
            bit_nx = bit_r + 4'd1;
          end
        end else begin
          ph_nx = ph_r + PH_W'(1);
        end
      end
      S_GAP: begin
        cnt_nx = '0;
        if (last_r) begin
          state_nx = S_END;
        end else begin
          src_nx   = idx_r;
          dummy_nx = 1'b0;
          state_nx = S_CONV;
          if (nch_s[3]) begin
            idx_nx  = nch_s[2:0];
            last_nx = 1'b0;
          end else begin
            idx_nx  = first_ch(mask_r);
            last_nx = 1'b1;
          end
        end
      end
      S_END: begin
        if (continuous && (ch_enable != 8'd0)) begin
          mask_nx  = ch_enable;
          idx_nx   = first_ch(ch_enable);
          dummy_nx = 1'b1;
          last_nx  = 1'b0;
          cnt_nx   = '0;
          state_nx = S_CONV;
        end else begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
    load_s    = (state_r == S_GAP) && !dummy_r;
    xfer_s    = rv_r && res.result_ready;
    sclk_nx_s = (state_nx == S_SHIFT) && (ph_nx >= PH_RISE);
    if (state_nx == S_SHIFT) begin
      din_nx_s = cfg_bit(idx_nx, bit_nx);
    end else begin
      din_nx_s = 1'b0;
    end
  end

  // FSM state, counters and channel bookkeeping registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= S_IDLE;
      cnt_r   <= '0;
      ph_r    <= '0;
      bit_r   <= 4'd0;
      mask_r  <= 8'd0;
      idx_r   <= 3'd0;
      src_r   <= 3'd0;
      dummy_r <= 1'b0;
      last_r  <= 1'b0;
      shift_r <= '0;
    end else begin
      state_r <= state_nx;
      cnt_r   <= cnt_nx;
      ph_r    <= ph_nx;
      bit_r   <= bit_nx;
      mask_r  <= mask_nx;
      idx_r   <= idx_nx;
      src_r   <= src_nx;
      dummy_r <= dummy_nx;
      last_r  <= last_nx;
      shift_r <= shift_nx;
    end
  end

  // ADC pins and status flags, registered from the upcoming state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      cs_r   <= 1'b0;
      sclk_r <= 1'b0;
      din_r  <= 1'b0;
    end else begin
      busy_r <= (state_nx != S_IDLE);
      done_r <= (state_nx == S_END);
      cs_r   <= (state_nx == S_CONV);
      sclk_r <= sclk_nx_s;
      din_r  <= din_nx_s;
    end
  end

  // Result holding register; a load over an untaken result flags overrun.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rv_r    <= 1'b0;
      ovr_r   <= 1'b0;
      rch_r   <= 3'd0;
      rdata_r <= '0;
    end else if (load_s) begin
      rv_r    <= 1'b1;
      ovr_r   <= rv_r && !res.result_ready;
      rch_r   <= src_r;
      rdata_r <= shift_r;
    end else begin
      rv_r    <= rv_r && !xfer_s;
      ovr_r   <= 1'b0;
    end
  end

  assign busy             = busy_r;
  assign scan_done        = done_r;
  assign adc_cs_n         = cs_r;
  assign adc_sclk         = sclk_r;
  assign adc_din          = din_r;
  assign res.result_valid = rv_r;
  assign res.result_ch    = rch_r;
  assign res.result_data  = rdata_r;
  assign res.overrun      = ovr_r;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Bench for adc_scan_sequencer: a behavioural convert-then-shift ADC model,
// pin monitors, and a result scoreboard filled when each scan is launched.
`timescale 1ns/1ps

module tb_adc_scan_sequencer;
  localparam int CLK_DIV     = 2;
  localparam int CONV_CYCLES = 8;
  localparam int RES_W       = 12;
  localparam int TXN_LEN     = CONV_CYCLES + 24 * CLK_DIV + 1;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] ch_enable;
  logic       scan_start, continuous;
  logic       busy, scan_done, adc_cs_n, adc_sclk, adc_din;
  logic       adc_dout = 1'b0;

  adc_scan_sequencer_if #(.RES_W(RES_W)) res_if ();

  adc_scan_sequencer #(.CLK_DIV(CLK_DIV), .CONV_CYCLES(CONV_CYCLES), .RES_W(RES_W)) dut (
    .clk(clk), .reset_n(reset_n), .ch_enable(ch_enable), .scan_start(scan_start),
    .continuous(continuous), .busy(busy), .scan_done(scan_done), .res(res_if),
    .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .adc_din(adc_din), .adc_dout(adc_dout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc = 0, conv_cnt = 0, done_cnt = 0, ovr_cnt = 0, done_cyc = 0, din_cnt = 0;
  int starts[$];
  logic [5:0]  din_words[$];
  logic [14:0] exp_q[$];
  logic        mode_fixed = 1'b1;
  logic [2:0]  cfg_ch = 3'd0;
  logic [11:0] conv_val = 12'd0, out_sr = 12'd0;
  logic [5:0]  din_sr = 6'd0;
  logic        prev_cs = 1'b0, prev_sclk = 1'b0;

  function automatic logic [5:0] cfg_word(input logic [2:0] ch);
    return {1'b1, ch[0], ch[2], ch[1], 1'b1, 1'b0};
  endfunction

  function automatic logic [11:0] echo(input logic [2:0] ch);
    return {1'b0, ch, 1'b0, ch, 1'b0, ch};
  endfunction

  // ADC model plus pin monitors, evaluated on the falling clock edge.
  always @(negedge clk) begin
    cyc++;
    if (adc_cs_n && !prev_cs) begin
      conv_cnt++;
      starts.push_back(cyc);
      din_cnt  = 0;
      conv_val = mode_fixed ? 12'hA5C : echo(cfg_ch);
    end
    if (!adc_cs_n && prev_cs) begin
      out_sr   = conv_val;
      adc_dout = out_sr[11];
    end
    if (!adc_sclk && prev_sclk) begin
      out_sr   = {out_sr[10:0], 1'b0};
      adc_dout = out_sr[11];
    end
    if (adc_sclk && !prev_sclk && din_cnt < 6) begin
      din_sr = {din_sr[4:0], adc_din};
      din_cnt++;
      if (din_cnt == 6) begin
        din_words.push_back(din_sr);
        cfg_ch = {din_sr[3], din_sr[2], din_sr[4]};
      end
    end
    if (scan_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (res_if.overrun) ovr_cnt++;
    prev_cs   = adc_cs_n;
    prev_sclk = adc_sclk;
  end

  task automatic pulse_start();
    @(negedge clk);
    scan_start = 1'b1;
    @(negedge clk);
    scan_start = 1'b0;
  endtask

  // Scoreboard drain: compare every transfer until the sequencer goes idle.
  task automatic run_until_idle(input int budget);
    logic [14:0] e;
    bit          idle;
    idle = 1'b0;
    for (int i = 0; i < budget && !idle; i++) begin
      @(negedge clk); #1;
      if (res_if.result_valid && res_if.result_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL result_extra got ch=%0d data=%h need none", res_if.result_ch, res_if.result_data);
        end else begin
          e = exp_q.pop_front();
          if ({res_if.result_ch, res_if.result_data} !== e) begin
            bad++;
            $display("FAIL result got ch=%0d data=%h need ch=%0d data=%h",
                     res_if.result_ch, res_if.result_data, e[14:12], e[11:0]);
          end
        end
      end
      if (!busy) idle = 1'b1;
    end
    if (!idle) begin
      total++; bad++;
      $display("FAIL idle_timeout busy=%0b need 0 within %0d cycles", busy, budget);
    end
  endtask

  task automatic test_reset();
    logic [21:0] outs;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    outs = {busy, scan_done, res_if.result_valid, res_if.result_ch, res_if.result_data,
            res_if.overrun, adc_cs_n, adc_sclk, adc_din};
    total++;
    if (outs !== 22'd0) begin bad++; $display("FAIL reset_outputs got %h need 0", outs); end
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    total++;
    if ({busy, adc_cs_n} !== 2'b00) begin bad++; $display("FAIL post_reset_idle got %b need 00", {busy, adc_cs_n}); end
  endtask

  task automatic test_single();
    int n0, s0, d0, dn0;
    mode_fixed = 1'b1; continuous = 1'b0; res_if.result_ready = 1'b1; ch_enable = 8'h01;
    n0 = conv_cnt; s0 = starts.size(); d0 = din_words.size(); dn0 = done_cnt;
    exp_q.push_back({3'd0, 12'hA5C});
    pulse_start(); #1;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got %b need 1", busy); end
    run_until_idle(300);
    total++;
    if (conv_cnt - n0 != 2) begin bad++; $display("FAIL single_txns got %0d need 2", conv_cnt - n0); end
    if (starts.size() >= s0 + 2) begin
      total++;
      if (starts[s0+1] - starts[s0] != TXN_LEN) begin
        bad++; $display("FAIL single_txn0_len got %0d need %0d", starts[s0+1] - starts[s0], TXN_LEN);
      end
      total++;
      if (done_cyc - starts[s0+1] != TXN_LEN) begin
        bad++; $display("FAIL single_txn1_len got %0d need %0d", done_cyc - starts[s0+1], TXN_LEN);
      end
    end
    total++;
    if (din_words.size() <= d0 || din_words[d0] !== cfg_word(3'd0)) begin
      bad++; $display("FAIL single_din got %b need %b", (din_words.size() > d0) ? din_words[d0] : 6'bx, cfg_word(3'd0));
    end
    total++;
    if (done_cnt - dn0 != 1 || exp_q.size() != 0) begin
      bad++; $display("FAIL single_done got done=%0d left=%0d need 1 0", done_cnt - dn0, exp_q.size());
    end
  endtask

  task automatic test_multi();
    int n0, d0;
    logic [2:0] chs[4];
    chs[0] = 3'd2; chs[1] = 3'd5; chs[2] = 3'd7; chs[3] = 3'd2;
    mode_fixed = 1'b0; res_if.result_ready = 1'b1; ch_enable = 8'b1010_0100;
    n0 = conv_cnt; d0 = din_words.size();
    for (int k = 0; k < 3; k++) exp_q.push_back({chs[k], echo(chs[k])});
    pulse_start();
    run_until_idle(600);
    total++;
    if (conv_cnt - n0 != 4) begin bad++; $display("FAIL multi_txns got %0d need 4", conv_cnt - n0); end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (din_words.size() <= d0 + k || din_words[d0+k] !== cfg_word(chs[k])) begin
        bad++; $display("FAIL multi_din%0d got %b need %b", k,
                        (din_words.size() > d0 + k) ? din_words[d0+k] : 6'bx, cfg_word(chs[k]));
      end
    end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL multi_left got %0d need 0", exp_q.size()); end
  endtask

  task automatic test_overrun();
    int o0;
    logic [14:0] e;
    mode_fixed = 1'b0; res_if.result_ready = 1'b0; ch_enable = 8'h03;
    o0 = ovr_cnt;
    exp_q.push_back({3'd1, echo(3'd1)});
    pulse_start();
    run_until_idle(600);
    total++;
    if (ovr_cnt - o0 != 1) begin bad++; $display("FAIL overrun_count got %0d need 1", ovr_cnt - o0); end
    e = exp_q.pop_front();
    total++;
    if ({res_if.result_valid, res_if.result_ch, res_if.result_data} !== {1'b1, e}) begin
      bad++; $display("FAIL overrun_held got v=%b ch=%0d data=%h need v=1 ch=%0d data=%h",
                      res_if.result_valid, res_if.result_ch, res_if.result_data, e[14:12], e[11:0]);
    end
    @(negedge clk); res_if.result_ready = 1'b1;
    @(negedge clk); res_if.result_ready = 1'b0; #1;
    total++;
    if (res_if.result_valid !== 1'b0) begin bad++; $display("FAIL overrun_clear got %b need 0", res_if.result_valid); end
  endtask

  task automatic test_continuous();
    int n0, dn0;
    mode_fixed = 1'b0; res_if.result_ready = 1'b1; continuous = 1'b1; ch_enable = 8'h01;
    n0 = conv_cnt; dn0 = done_cnt;
    exp_q.push_back({3'd0, echo(3'd0)});
    exp_q.push_back({3'd7, echo(3'd7)});
    pulse_start();
    ch_enable = 8'h80;
    fork
      run_until_idle(900);
      begin
        for (int k = 0; k < 600 && done_cnt == dn0; k++) @(negedge clk);
        repeat (10) @(negedge clk);
        continuous = 1'b0;
      end
    join
    total++;
    if (done_cnt - dn0 != 2) begin bad++; $display("FAIL cont_done got %0d need 2", done_cnt - dn0); end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL cont_left got %0d need 0", exp_q.size()); end
    repeat (100) @(negedge clk);
    total++;
    if (conv_cnt - n0 != 4 || busy !== 1'b0) begin
      bad++; $display("FAIL cont_stop got txns=%0d busy=%b need 4 0", conv_cnt - n0, busy);
    end
  endtask

  task automatic test_ignored();
    int n0, dn0;
    mode_fixed = 1'b1; res_if.result_ready = 1'b1; ch_enable = 8'h00;
    n0 = conv_cnt; dn0 = done_cnt;
    pulse_start();
    repeat (20) @(negedge clk);
    total++;
    if (busy !== 1'b0 || conv_cnt != n0) begin
      bad++; $display("FAIL empty_mask got busy=%b txns=%0d need 0 0", busy, conv_cnt - n0);
    end
    ch_enable = 8'h01;
    exp_q.push_back({3'd0, 12'hA5C});
    pulse_start();
    repeat (5) @(negedge clk);
    ch_enable = 8'hFF;
    pulse_start();
    run_until_idle(300);
    total++;
    if (conv_cnt - n0 != 2 || done_cnt - dn0 != 1 || exp_q.size() != 0) begin
      bad++; $display("FAIL busy_start got txns=%0d done=%0d left=%0d need 2 1 0",
                      conv_cnt - n0, done_cnt - dn0, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int n0, dn0;
    logic [21:0] outs;
    mode_fixed = 1'b0; res_if.result_ready = 1'b1; ch_enable = 8'hFF;
    pulse_start();
    for (int k = 0; k < 200 && !adc_sclk; k++) @(negedge clk);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    outs = {busy, scan_done, res_if.result_valid, res_if.result_ch, res_if.result_data,
            res_if.overrun, adc_cs_n, adc_sclk, adc_din};
    total++;
    if (outs !== 22'd0) begin bad++; $display("FAIL reset_mid got %h need 0", outs); end
    n0 = conv_cnt; dn0 = done_cnt;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (50) @(negedge clk);
    total++;
    if (busy !== 1'b0 || conv_cnt != n0 || done_cnt != dn0) begin
      bad++; $display("FAIL reset_idle got busy=%b txns=%0d done=%0d need 0 0 0", busy, conv_cnt - n0, done_cnt - dn0);
    end
    ch_enable = 8'h01;
    exp_q.push_back({3'd0, echo(3'd0)});
    pulse_start();
    run_until_idle(300);
    total++;
    if (done_cnt - dn0 != 1 || exp_q.size() != 0) begin
      bad++; $display("FAIL reset_rescan got done=%0d left=%0d need 1 0", done_cnt - dn0, exp_q.size());
    end
  endtask

  initial begin
    scan_start = 1'b0; continuous = 1'b0; ch_enable = 8'h00;
    res_if.result_ready = 1'b0; reset_n = 1'b0;
    test_reset();
    test_single();
    test_multi();
    test_overrun();
    test_continuous();
    test_ignored();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1);
  end

endmodule
